// File: rtl/fifo_pkg.sv
// Shared widths and pointer/count types for the dual-port-RAM FIFO controller.
package fifo_pkg;
   localparam int unsigned FIFO_DATA_W = 8;
   localparam int unsigned FIFO_ADDR_W = 4;

   typedef logic [FIFO_ADDR_W-1:0] ptr_t;
   typedef logic [FIFO_ADDR_W:0]   cnt_t;
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer; advances by one when inc is high.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int unsigned W = FIFO_ADDR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // Natural W-bit overflow provides the modulo-DEPTH wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr + W'(inc);
   end

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// FWFT FIFO controller in front of a read-first, 1-cycle-latency dual-port RAM.
// Optional FIFO_LEVEL_EN adds level and almost_full outputs.
module dp_ram_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
`ifdef FIFO_LEVEL_EN
   output logic [ADDR_W:0]   level,
   output logic              almost_full,
`endif
   output logic              ram_we_a,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [DATA_W-1:0] ram_din_a,
   output logic              ram_we_b,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic [DATA_W-1:0] ram_din_b,
   input  logic [DATA_W-1:0] ram_dout_b
);

   localparam int unsigned       DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_ptr_nxt;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_nxt;

   // rst_n gate keeps a write from reaching the RAM while reset is held.
   always_comb begin
      s_ready    = (count != FULL_CNT);
      push       = s_valid & s_ready & rst_n;
      pop        = m_valid & m_ready;
      rd_ptr_nxt = rd_ptr + ADDR_W'(pop);
      count_nxt  = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
   end

   fifo_ptr #(.W(ADDR_W)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push),
      .ptr   (wr_ptr)
   );

   fifo_ptr #(.W(ADDR_W)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop),
      .ptr   (rd_ptr)
   );

   // Port B is addressed with the post-pop head so the RAM register
   // lands the new head on the same edge as the pop.
   always_comb begin
      ram_we_a   = push;
      ram_addr_a = wr_ptr;
      ram_din_a  = s_data;
      ram_we_b   = 1'b0;
      ram_addr_b = rd_ptr_nxt;
      ram_din_b  = '0;
      m_data     = ram_dout_b;
   end

   // A same-edge push is excluded from m_valid: read-first RAM hides it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         m_valid <= 1'b0;
      end else begin
         count   <= count_nxt;
         m_valid <= ((count - (ADDR_W+1)'(pop)) != '0);
      end
   end

`ifdef FIFO_LEVEL_EN
   assign level = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) almost_full <= 1'b0;
      else        almost_full <= (count_nxt >= (FULL_CNT - (ADDR_W+1)'(2)));
   end
`endif

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Directed bench for dp_ram_fifo_ctrl with a behavioural read-first 16x8 RAM.
module tb_dp_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;
   logic       ram_we_a;
   logic [3:0] ram_addr_a;
   logic [7:0] ram_din_a;
   logic       ram_we_b;
   logic [3:0] ram_addr_b;
   logic [7:0] ram_din_b;
   logic [7:0] ram_dout_b;
`ifdef FIFO_LEVEL_EN
   logic [4:0] level;
   logic       almost_full;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dp_ram_fifo_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
`ifdef FIFO_LEVEL_EN
      .level      (level),
      .almost_full(almost_full),
`endif
      .ram_we_a   (ram_we_a),
      .ram_addr_a (ram_addr_a),
      .ram_din_a  (ram_din_a),
      .ram_we_b   (ram_we_b),
      .ram_addr_b (ram_addr_b),
      .ram_din_b  (ram_din_b),
      .ram_dout_b (ram_dout_b)
   );

   // RAM model: no reset, read-first, registered port-B output.
   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      ram_dout_b <= mem[ram_addr_b];
   end

   typedef struct {
      logic       sv;
      logic [7:0] d;
      logic       mr;
      logic       ex_sr;
      logic       ex_mv;
      logic [7:0] ex_md;
      logic       ex_we;
      int         ex_cnt;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(logic sv, logic [7:0] d, logic mr, logic sr,
                               logic mv, logic [7:0] md, logic we, int cnt);
      vec_t v;
      v.sv = sv; v.d = d; v.mr = mr; v.ex_sr = sr;
      v.ex_mv = mv; v.ex_md = md; v.ex_we = we; v.ex_cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive inputs on the falling edge, then settle before sampling.
   task automatic step(input logic sv, input logic [7:0] d, input logic mr);
      @(negedge clk);
      s_valid = sv;
      s_data  = d;
      m_ready = mr;
      #1;
   endtask

   logic [7:0] q [$];
   int         sent, got;
   logic [3:0] prev_addr;
   logic       wrapped;

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'h77;
      m_ready = 1'b1;

      // Reset held with a pending write: nothing may complete.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         chk("rst_s_ready", s_ready, 1);
         chk("rst_m_valid", m_valid, 0);
         chk("rst_we_a", ram_we_a, 0);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      s_valid = 1'b0;
      step(0, 8'h00, 1);
      chk("post_rst_cnt", dut.count, 0);
      chk("post_rst_m_valid", m_valid, 0);

      // Single word, then push+pop with one queued word and a held head.
      tbl[0]  = mk(1, 8'hA5, 0, 1, 0, 8'h00, 1, 0);
      tbl[1]  = mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 1);
      tbl[2]  = mk(0, 8'h00, 1, 1, 1, 8'hA5, 0, 1);
      tbl[3]  = mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
      tbl[4]  = mk(1, 8'h11, 0, 1, 0, 8'h00, 1, 0);
      tbl[5]  = mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 1);
      tbl[6]  = mk(0, 8'h00, 0, 1, 1, 8'h11, 0, 1);
      tbl[7]  = mk(1, 8'h22, 1, 1, 1, 8'h11, 1, 1);
      tbl[8]  = mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 1);
      tbl[9]  = mk(0, 8'h00, 0, 1, 1, 8'h22, 0, 1);
      tbl[10] = mk(0, 8'h00, 0, 1, 1, 8'h22, 0, 1);
      tbl[11] = mk(0, 8'h00, 1, 1, 1, 8'h22, 0, 1);
      tbl[12] = mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0);

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].sv, tbl[i].d, tbl[i].mr);
         chk($sformatf("v%0d_s_ready", i), s_ready, tbl[i].ex_sr);
         chk($sformatf("v%0d_m_valid", i), m_valid, tbl[i].ex_mv);
         chk($sformatf("v%0d_we_a", i), ram_we_a, tbl[i].ex_we);
         chk($sformatf("v%0d_count", i), dut.count, tbl[i].ex_cnt);
         if (tbl[i].ex_mv) chk($sformatf("v%0d_m_data", i), m_data, tbl[i].ex_md);
      end

      // Fill to full with the consumer stalled.
      for (int i = 0; i < 16; i++) begin
         step(1, 8'(i), 0);
         chk("fill_s_ready", s_ready, 1);
         chk("fill_we_a", ram_we_a, 1);
      end
      step(1, 8'h99, 0);
      chk("full_s_ready", s_ready, 0);
      chk("full_we_a", ram_we_a, 0);
      chk("full_count", dut.count, 16);
      chk("full_head", m_data, 8'h00);

      // Push and pop together at full: push refused.
      step(1, 8'h99, 1);
      chk("fullpp_we_a", ram_we_a, 0);
      chk("fullpp_m_valid", m_valid, 1);
      chk("fullpp_m_data", m_data, 8'h00);

      // Drain at one word per clock.
      for (int i = 1; i < 16; i++) begin
         step(0, 8'h00, 1);
         if (i == 1) chk("after_fullpp_count", dut.count, 15);
         chk("drain_m_valid", m_valid, 1);
         chk("drain_m_data", m_data, i);
      end
      step(0, 8'h00, 1);
      chk("drained_m_valid", m_valid, 0);
      chk("drained_count", dut.count, 0);

      // Continuous stream of 40 words across pointer wrap.
      sent = 0; got = 0; wrapped = 1'b0; prev_addr = 4'h0;
      for (int cyc = 0; cyc < 300 && got < 40; cyc++) begin
         step(sent < 40, 8'(8'h40 + sent), 1);
         if (s_valid && s_ready) begin
            q.push_back(s_data);
            if (sent > 0 && prev_addr == 4'hF && ram_addr_a == 4'h0) wrapped = 1'b1;
            prev_addr = ram_addr_a;
            sent++;
         end
         if (dut.count > 16) chk("stream_count_le_depth", dut.count, 16);
         if (m_valid) begin
            if (q.size() == 0) chk("stream_unexpected_word", m_data, -1);
            else               chk("stream_data", m_data, q.pop_front());
            got++;
         end
      end
      chk("stream_words_out", got, 40);
      chk("stream_addr_a_wrap", wrapped, 1);

      // Asynchronous reset with five words queued.
      for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0);
      step(0, 8'h00, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_valid", m_valid, 0);
      chk("arst_count", dut.count, 0);
      chk("arst_s_ready", s_ready, 1);
      #1 rst_n = 1'b1;
      step(1, 8'h3C, 0);
      chk("arst_push_we_a", ram_we_a, 1);
      step(0, 8'h00, 0);
      chk("arst_lat_m_valid", m_valid, 0);
      step(0, 8'h00, 0);
      chk("arst_first_m_valid", m_valid, 1);
      chk("arst_first_m_data", m_data, 8'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
